// File: rtl/astar_pkg.sv
// astar_pkg: grid geometry, direction offsets, error codes and cell addressing shared by the path reconstructor
package astar_pkg;
    localparam int GRID_W = 40;
    localparam int GRID_H = 40;
    localparam int COORD_W = 8;
    localparam int CELLS = GRID_W * GRID_H;
    localparam int MAX_STEPS = CELLS;
    localparam int IDX_W = 11;
    localparam logic [COORD_W-1:0] NULL_COORD = 8'hFF;

    typedef enum logic [2:0] {
        DIR_NW, DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W
    } dir_e;

    // Offsets are added modulo 256, so a step off the west/north edge lands on 255 and fails the bounds test
    localparam logic [COORD_W-1:0] DX [8] = '{8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'hFF, 8'hFF};
    localparam logic [COORD_W-1:0] DY [8] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00};

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_MISSING = 2'd1;
    localparam logic [1:0] ERR_BOUNDS  = 2'd2;
    localparam logic [1:0] ERR_STEPS   = 2'd3;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_EMIT, S_LOOKUP, S_STEP, S_DONE, S_ERR
    } state_e;

    function automatic logic in_grid(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        return x < COORD_W'(GRID_W) && y < COORD_W'(GRID_H);
    endfunction

    function automatic logic [IDX_W-1:0] cell_index(logic [COORD_W-1:0] x, logic [COORD_W-1:0] y);
        return ({3'b0, y} << 5) + ({3'b0, y} << 3) + {3'b0, x};
    endfunction
endpackage

// File: rtl/astar_path_reconstructor_if.sv
// astar_path_reconstructor_if: valid/ready stream of reconstructed path cells
interface astar_path_reconstructor_if;
    import astar_pkg::*;
    logic path_valid;
    logic path_ready;
    logic [COORD_W-1:0] path_x;
    logic [COORD_W-1:0] path_y;
    modport master (output path_valid, path_x, path_y, input path_ready);
    modport slave (input path_valid, path_x, path_y, output path_ready);
endinterface

// File: rtl/astar_grid_ram.sv
// astar_grid_ram: one-entry-per-cell RAM with one write port and one registered read port
module astar_grid_ram
    import astar_pkg::*;
#(
    parameter int W = 1
) (
    input  logic sync,
    input  logic we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [W-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [W-1:0] rdata
);
    logic [W-1:0] mem [CELLS];

    always_ff @(posedge sync) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/astar_path_reconstructor.sv
// astar_path_reconstructor: walks the parent chain from goal to start, streaming and marking each path cell
module astar_path_reconstructor
    import astar_pkg::*;
(
    input  logic sync,
    input  logic reset,
    input  logic clear,
    input  logic par_we,
    input  logic [COORD_W-1:0] par_x,
    input  logic [COORD_W-1:0] par_y,
    input  logic [2:0] par_dir,
    input  logic start,
    input  logic [COORD_W-1:0] start_x,
    input  logic [COORD_W-1:0] start_y,
    input  logic [COORD_W-1:0] goal_x,
    input  logic [COORD_W-1:0] goal_y,
    astar_path_reconstructor_if.master path,
    output logic [IDX_W-1:0] path_len,
    output logic busy,
    output logic done,
    output logic error,
    output logic [1:0] err_code,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic rd_path
);
    state_e state, state_n;
    logic [IDX_W-1:0] idx;
    logic [COORD_W-1:0] cur_x, cur_y, end_x, end_y, nx, ny;
    logic [3:0] par_q;
    logic bm_q, rd_ok, idle_like, take_clear, take_start, start_ok, fire, at_end, last_step, step_ok;

    assign idle_like = state inside {S_IDLE, S_DONE, S_ERR};
    assign take_clear = idle_like && clear;
    assign take_start = idle_like && start && !clear;
    assign start_ok = in_grid(start_x, start_y) && in_grid(goal_x, goal_y);
    assign fire = state == S_EMIT && path.path_ready;
    assign at_end = cur_x == end_x && cur_y == end_y;
    assign last_step = path_len == IDX_W'(MAX_STEPS - 1);
    assign nx = cur_x + DX[dir_e'(par_q[2:0])];
    assign ny = cur_y + DY[dir_e'(par_q[2:0])];
    assign step_ok = par_q[3] && in_grid(nx, ny);

    always_comb begin
        state_n = state;
        case (state)
            S_CLEAR:  state_n = idx == IDX_W'(CELLS - 1) ? S_IDLE : S_CLEAR;
            S_EMIT:   state_n = !path.path_ready ? S_EMIT : at_end ? S_DONE : last_step ? S_ERR : S_LOOKUP;
            S_LOOKUP: state_n = S_STEP;
            S_STEP:   state_n = step_ok ? S_EMIT : S_ERR;
            default:  state_n = take_clear ? S_CLEAR : take_start ? (start_ok ? S_EMIT : S_ERR) : state;
        endcase
    end

    always_ff @(posedge sync) begin
        if (reset) begin
            state <= S_CLEAR;
            idx <= '0;
            cur_x <= '0;
            cur_y <= '0;
            end_x <= '0;
            end_y <= '0;
            path_len <= '0;
            done <= 1'b0;
            error <= 1'b0;
            err_code <= ERR_NONE;
            rd_ok <= 1'b0;
        end else begin
            state <= state_n;
            idx <= state == S_CLEAR ? idx + 1'b1 : '0;
            rd_ok <= in_grid(rd_x, rd_y);
            if (take_clear || take_start) begin
                path_len <= '0;
                done <= 1'b0;
                error <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (take_start) begin
                cur_x <= goal_x;
                cur_y <= goal_y;
                end_x <= start_x;
                end_y <= start_y;
                if (!start_ok) begin
                    error <= 1'b1;
                    err_code <= ERR_BOUNDS;
                end
            end
            if (fire) begin
                path_len <= path_len + 1'b1;
                done <= at_end;
                if (!at_end && last_step) begin
                    error <= 1'b1;
                    err_code <= ERR_STEPS;
                end
            end
            if (state == S_STEP) begin
                if (step_ok) begin
                    cur_x <= nx;
                    cur_y <= ny;
                end else begin
                    error <= 1'b1;
                    err_code <= par_q[3] ? ERR_BOUNDS : ERR_MISSING;
                end
            end
        end
    end

    // Reset gates the combinational outputs so nothing is asserted while reset is held
    assign busy = !reset && state inside {S_CLEAR, S_EMIT, S_LOOKUP, S_STEP};
    assign path.path_valid = !reset && state == S_EMIT;
    assign path.path_x = cur_x;
    assign path.path_y = cur_y;
    assign rd_path = bm_q && rd_ok;

    astar_grid_ram #(.W(4)) u_parent (
        .sync(sync),
        .we(state == S_CLEAR || (idle_like && par_we && in_grid(par_x, par_y))),
        .waddr(state == S_CLEAR ? idx : cell_index(par_x, par_y)),
        .wdata(state == S_CLEAR ? 4'b0 : {1'b1, par_dir}),
        .raddr(cell_index(cur_x, cur_y)),
        .rdata(par_q)
    );

    astar_grid_ram #(.W(1)) u_bitmap (
        .sync(sync),
        .we(state == S_CLEAR || fire),
        .waddr(state == S_CLEAR ? idx : cell_index(cur_x, cur_y)),
        .wdata(state != S_CLEAR),
        .raddr(cell_index(rd_x, rd_y)),
        .rdata(bm_q)
    );
endmodule

// File: doc/astar_path_reconstructor.md
Name: astar_path_reconstructor

Overview:
- Downstream stage of the A* search core on the 40x40 grid.
- The search core writes a parent direction for each cell it expands into an internal parent table. When the goal is reached, this block walks the parent chain from goal back to start.
- Each path cell is streamed out over a valid/ready interface and marked in a path bitmap.
- The grid renderer reads the bitmap by (x,y) to drive draw_path.

Parameters:
- GRID_W, 40, grid width in cells.
- GRID_H, 40, grid height in cells.
- COORD_W, 8, coordinate width; 8'hFF is never a legal cell.
- MAX_STEPS, 1600, emitted-cell limit before loop error (GRID_W*GRID_H).

Ports:
- sync  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  pulse; invalidates the parent table and zeroes the path bitmap
- par_we  in  1  parent write strobe from the search core
- par_x, par_y  in  COORD_W  cell being written
- par_dir  in  3  direction from the cell to its parent
- start  in  1  pulse; begin walk
- start_x, start_y  in  COORD_W  search start cell (walk terminus)
- goal_x, goal_y  in  COORD_W  goal cell (walk origin)
- path_valid  out  1  path beat valid
- path_ready  in  1  consumer accept
- path_x, path_y  out  COORD_W  path cell
- path_len  out  11  cells emitted so far; final value valid with done
- busy  out  1  clearing or walking
- done  out  1  level; walk reached start
- error  out  1  level; walk aborted
- err_code  out  2  0 none, 1 missing parent, 2 out of bounds, 3 step overflow
- rd_x, rd_y  in  COORD_W  renderer bitmap address
- rd_path  out  1  bitmap bit, registered, 1-cycle latency

Behaviour:
- **Direction codes** (y increases southward): 0 NW(-1,-1), 1 N(0,-1), 2 NE(+1,-1), 3 E(+1,0), 4 SE(+1,+1), 5 S(0,+1), 6 SW(-1,+1), 7 W(-1,0).
- **Addressing:** cell index = y*40+x, 11 bits, computed as (y<<5)+(y<<3)+x with no multiplier. The parent table stores {valid, dir} in 4 bits per cell.
- **Reset:** while reset is high, all outputs are 0 and state=CLEAR with index 0. After release, CLEAR runs.
- **CLEAR:** one cell per cycle over indices 0..1599, zeroing the parent valid bit and the path bit; 1600 cycles with busy=1. Then IDLE, with done, error, err_code and path_len all 0.
- **Parent writes:** par_we is honoured only in IDLE, DONE and ERR, and sets valid=1 with dir. It is ignored in other states. Writes with coordinates outside the grid are dropped.
- **Start acceptance:** start is accepted in IDLE, DONE and ERR. On accept: latch start and goal, cur=goal, path_len=0, clear done/error/err_code, busy=1.
  - If either latched coordinate is out of grid: go to ERR with code 2 and emit nothing.
  - Otherwise go to EMIT.
- **EMIT:** path_valid=1 with path_x/y=cur, held stable until path_ready. On handshake:
  - set bitmap[cur]=1 and path_len+1;
  - if cur==start, go to DONE;
  - else if path_len+1==MAX_STEPS, go to ERR with code 3;
  - else go to LOOKUP.
- **LOOKUP:** issue a synchronous parent read at cur (1 cycle), then go to STEP.
- **STEP:**
  - valid=0: go to ERR with code 1.
  - next=cur+offset(dir) falls outside 0..39 on either axis: go to ERR with code 2.
  - Otherwise cur=next and go to EMIT.
- **Throughput:** 3 cycles per cell with path_ready held high.
- **DONE / ERR:** busy=0; done or error is held until the next accepted start or a clear.
- **clear:** accepted in IDLE, DONE and ERR. If clear and start arrive in the same cycle, clear wins and start is dropped. clear while busy is ignored.
- **Bitmap lifetime:** the bitmap is not cleared by start; consecutive walks accumulate until a clear.
- **par_we and start in the same cycle:** the write lands; the first lookup is at least 2 cycles later, so it sees the new entry.
- **Renderer read:** rd_path is valid in every state. Out-of-grid rd_x/rd_y returns 0. During CLEAR, cells already cleared read 0.
- **Reset mid-walk:** abandons the walk, drops the beat (path_valid goes 0) and re-runs CLEAR.

Decomposition:
- **astar_pkg:** GRID_W, GRID_H, COORD_W, NULL_COORD=8'hFF, direction enum and dx/dy offset tables, err_code constants, cell_index function.
- **Sub-module astar_grid_ram:** parameterised-width 1600-entry RAM with one write port and one synchronous read port.
  - Instantiated for the parent table (4 bits wide).
  - Instantiated for the path bitmap (1 bit wide). The bitmap read port serves the renderer; the walk only writes.

Test Plan:
- **Reset/clear:** pulse reset -> busy=1 for exactly 1600 cycles, then 0. rd_path at (0,0), (39,39) and (12,30) = 0.
- **Diagonal walk:** write dir=0 at (k,k) for k=1..39; start=(0,0), goal=(39,39), ready high -> 40 beats (39,39)..(0,0), 3 cycles apart. done=1, path_len=40; rd_path(5,5)=1, rd_path(5,6)=0.
- **Trivial path:** start=goal=(7,3) -> single beat (7,3), done, path_len=1.
- **Missing parent:** goal=(2,0) with dir=7, no entry at (1,0) -> beats (2,0),(1,0), then error with err_code=1, path_len=2.
- **Out of bounds and loop:**
  - (0,5) dir=7 with goal=(0,5) -> one beat, then err_code=2.
  - (3,3) dir=3 and (4,3) dir=7, start=(0,0), goal=(3,3) -> 1600 beats, then err_code=3.
- **Backpressure/conflicts:**
  - path_ready random 50% -> identical sequence to the diagonal case, no duplicate or dropped beats, path_x/y stable while stalled.
  - start and clear in the same cycle -> clear only (1600 busy cycles, no beats).
